// File: rtl/spi_master_burst.sv
// SPI master: per-transaction mode/CS, multi-word bursts under one held CS_n; o_RX_DV at SHIFT entry + (2*DATA_W+1)*CLKS_PER_HALF_BIT.
// Words are accepted only while o_TX_Ready is high (IDLE or WAIT_NEXT); strobes at other times are dropped, no queueing.
module spi_master_burst #(
   parameter int DATA_W            = 8,
   parameter int NUM_CS            = 2,
   parameter int CLKS_PER_HALF_BIT = 2,
   parameter int CS_LEAD_CLKS      = 1,
   parameter int CS_IDLE_CLKS      = 2,
   localparam int CSW              = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              i_Clk,
   input  logic              i_Rst_L,
   input  logic [1:0]        i_Mode,
   input  logic [CSW-1:0]    i_CS_Sel,
   input  logic [DATA_W-1:0] i_TX_Word,
   input  logic              i_TX_Last,
   input  logic              i_TX_DV,
   input  logic              i_CS_Release,
   output logic              o_TX_Ready,
   output logic              o_RX_DV,
   output logic [DATA_W-1:0] o_RX_Word,
   output logic              o_Busy,
   output logic              o_SPI_Clk,
   input  logic              i_SPI_MISO,
   output logic              o_SPI_MOSI,
   output logic [NUM_CS-1:0] o_SPI_CS_n
);
   localparam int BIT_W  = $clog2(DATA_W + 1);
   localparam int HALF_W = $clog2(CLKS_PER_HALF_BIT);
   localparam int WMAX   = (CS_LEAD_CLKS > CS_IDLE_CLKS) ? CS_LEAD_CLKS : CS_IDLE_CLKS;
   localparam int WAIT_W = $clog2(WMAX + 1);

   typedef enum logic [2:0] {S_IDLE, S_CS_LEAD, S_SHIFT, S_WAIT_NEXT, S_CS_IDLE} state_t;

   state_t              r_State, w_Next;
   logic                w_Ready, w_Busy, w_Accept, w_Tick, w_Done, w_CPHA_Acc;
   logic                w_Lead_Done, w_Idle_Done;
   logic [NUM_CS-1:0]   w_CS_n;
   logic                r_CPHA, r_Last, r_Lead, r_SPI_Clk, r_MOSI, r_RX_DV;
   logic [DATA_W-1:0]   r_TX_Shift, r_RX_Shift, r_RX_Word;
   logic [BIT_W-1:0]    r_Bit_Cnt;
   logic [HALF_W-1:0]   r_Half;
   logic [WAIT_W-1:0]   r_Wait_Cnt;
   logic [NUM_CS-1:0]   r_CS_n;

   assign w_Accept    = i_TX_DV && w_Ready;
   assign w_Tick      = (r_State == S_SHIFT) && (r_Half == HALF_W'(CLKS_PER_HALF_BIT - 1));
   // The tick after the last trailing edge is the closing half-bit wait.
   assign w_Done      = w_Tick && (r_Bit_Cnt == '0);
   assign w_Lead_Done = (r_State == S_CS_LEAD) && (r_Wait_Cnt == WAIT_W'(CS_LEAD_CLKS - 1));
   assign w_Idle_Done = (r_State == S_CS_IDLE) && (r_Wait_Cnt == WAIT_W'(CS_IDLE_CLKS - 1));
   assign w_CPHA_Acc  = (r_State == S_IDLE) ? i_Mode[0] : r_CPHA;

   always_comb begin
      w_CS_n = '1;
      for (int i = 0; i < NUM_CS; i++)
         if (i_CS_Sel == CSW'(i)) w_CS_n[i] = 1'b0;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) r_State <= S_IDLE;
      else          r_State <= w_Next;
   end

   always_comb begin
      w_Next  = r_State;
      w_Ready = 1'b0;
      w_Busy  = 1'b1;
      case (r_State)
         S_IDLE: begin
            w_Ready = 1'b1;
            w_Busy  = 1'b0;
            if (i_TX_DV) w_Next = S_CS_LEAD;
         end
         S_CS_LEAD: if (w_Lead_Done) w_Next = S_SHIFT;
         S_SHIFT:   if (w_Done) w_Next = r_Last ? S_CS_IDLE : S_WAIT_NEXT;
         S_WAIT_NEXT: begin
            w_Ready = 1'b1;
            if (i_TX_DV)           w_Next = S_SHIFT;
            else if (i_CS_Release) w_Next = S_CS_IDLE;
         end
         S_CS_IDLE: if (w_Idle_Done) w_Next = S_IDLE;
         default:   w_Next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_CPHA     <= 1'b0;
         r_Last     <= 1'b0;
         r_Lead     <= 1'b1;
         r_SPI_Clk  <= 1'b0;
         r_MOSI     <= 1'b0;
         r_RX_DV    <= 1'b0;
         r_TX_Shift <= '0;
         r_RX_Shift <= '0;
         r_RX_Word  <= '0;
         r_Bit_Cnt  <= '0;
         r_Half     <= '0;
         r_Wait_Cnt <= '0;
         r_CS_n     <= '1;
      end else begin
         r_RX_DV <= 1'b0;

         if (w_Next != r_State)
            r_Wait_Cnt <= '0;
         else if (r_State == S_CS_LEAD || r_State == S_CS_IDLE)
            r_Wait_Cnt <= r_Wait_Cnt + WAIT_W'(1);

         if (w_Accept) begin
            r_Last <= i_TX_Last;
            if (r_State == S_IDLE) begin
               r_CPHA    <= i_Mode[0];
               r_SPI_Clk <= i_Mode[1];
               r_CS_n    <= w_CS_n;
            end
            // CPHA=0 must present the MSB before the first leading edge.
            if (w_CPHA_Acc) begin
               r_TX_Shift <= i_TX_Word;
            end else begin
               r_MOSI     <= i_TX_Word[DATA_W-1];
               r_TX_Shift <= {i_TX_Word[DATA_W-2:0], 1'b0};
            end
         end

         if (w_Next == S_SHIFT && r_State != S_SHIFT) begin
            r_Half    <= '0;
            r_Bit_Cnt <= BIT_W'(DATA_W);
            r_Lead    <= 1'b1;
         end else if (r_State == S_SHIFT) begin
            r_Half <= w_Tick ? '0 : r_Half + HALF_W'(1);
         end

         if (w_Tick && r_Bit_Cnt != '0) begin
            r_SPI_Clk <= ~r_SPI_Clk;
            r_Lead    <= ~r_Lead;
            if (r_Lead) begin
               if (r_CPHA) begin
                  r_MOSI     <= r_TX_Shift[DATA_W-1];
                  r_TX_Shift <= {r_TX_Shift[DATA_W-2:0], 1'b0};
               end else begin
                  r_RX_Shift <= {r_RX_Shift[DATA_W-2:0], i_SPI_MISO};
               end
            end else begin
               r_Bit_Cnt <= r_Bit_Cnt - BIT_W'(1);
               if (r_CPHA) begin
                  r_RX_Shift <= {r_RX_Shift[DATA_W-2:0], i_SPI_MISO};
               end else if (r_Bit_Cnt != BIT_W'(1)) begin
                  r_MOSI     <= r_TX_Shift[DATA_W-1];
                  r_TX_Shift <= {r_TX_Shift[DATA_W-2:0], 1'b0};
               end
            end
         end

         if (w_Done) begin
            r_RX_DV   <= 1'b1;
            r_RX_Word <= r_RX_Shift;
         end

         if (w_Next == S_CS_IDLE && r_State != S_CS_IDLE) begin
            r_CS_n <= '1;
            r_MOSI <= 1'b0;
         end
      end
   end

   assign o_TX_Ready = w_Ready;
   assign o_Busy     = w_Busy;
   assign o_RX_DV    = r_RX_DV;
   assign o_RX_Word  = r_RX_Word;
   assign o_SPI_Clk  = r_SPI_Clk;
   assign o_SPI_MOSI = r_MOSI;
   assign o_SPI_CS_n = r_CS_n;
endmodule

// File: tb/tb_spi_master_burst.sv
// Scoreboard bench for spi_master_burst: loopback or fixed-word slave on MISO, expected RX words queued at accept.
module tb_spi_master_burst;
   localparam int DW   = 8;
   localparam int NCS  = 2;
   localparam int CPHB = 2;
   localparam int LEAD = 1;

   logic          i_Clk = 1'b0;
   logic          i_Rst_L = 1'b1;
   logic [1:0]    i_Mode = 2'b00;
   logic          i_CS_Sel = 1'b0;
   logic [DW-1:0] i_TX_Word = '0;
   logic          i_TX_Last = 1'b0;
   logic          i_TX_DV = 1'b0;
   logic          i_CS_Release = 1'b0;
   logic          o_TX_Ready, o_RX_DV, o_Busy, o_SPI_Clk, o_SPI_MOSI;
   logic [DW-1:0] o_RX_Word;
   logic [NCS-1:0] o_SPI_CS_n;
   logic          spi_miso;

   spi_master_burst #(.DATA_W(DW), .NUM_CS(NCS), .CLKS_PER_HALF_BIT(CPHB),
                      .CS_LEAD_CLKS(LEAD), .CS_IDLE_CLKS(2)) dut (
      .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_Mode(i_Mode), .i_CS_Sel(i_CS_Sel),
      .i_TX_Word(i_TX_Word), .i_TX_Last(i_TX_Last), .i_TX_DV(i_TX_DV),
      .i_CS_Release(i_CS_Release), .o_TX_Ready(o_TX_Ready), .o_RX_DV(o_RX_DV),
      .o_RX_Word(o_RX_Word), .o_Busy(o_Busy), .o_SPI_Clk(o_SPI_Clk),
      .i_SPI_MISO(spi_miso), .o_SPI_MOSI(o_SPI_MOSI), .o_SPI_CS_n(o_SPI_CS_n));

   always #5 i_Clk = ~i_Clk;

   int errors = 0;
   int checks = 0;
   int rx_count = 0;
   int rx_total = 0;
   logic [DW-1:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Slave: counts SCLK edges relative to the current CPOL and shifts slv_word out MSB first.
   logic          use_slave = 1'b0;
   logic [DW-1:0] slv_word = '0;
   logic [1:0]    cur_mode = 2'b00;
   int            lead_n = 0;
   int            trail_n = 0;
   logic          slv_bit;

   always @(o_SPI_Clk) begin
      if (o_SPI_Clk != cur_mode[1]) lead_n++;
      else if (lead_n > trail_n)    trail_n++;
   end

   always_comb begin
      int idx;
      logic [DW-1:0] tmp;
      idx = cur_mode[0] ? (DW - lead_n) : (DW - 1 - trail_n);
      if (idx < 0 || idx > DW - 1) idx = DW - 1;
      tmp = slv_word >> idx;
      slv_bit = tmp[0];
   end

   assign spi_miso = use_slave ? slv_bit : o_SPI_MOSI;

   logic [NCS-1:0] cs_exp = '1;
   logic           cs_watch = 1'b0;
   int             cs_bad = 0;

   always @(negedge i_Clk) begin
      if (o_RX_DV) begin
         rx_count++;
         check_val("rx_expected_pending", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            check_val("rx_word", o_RX_Word, exp_q.pop_front());
            check_val("sclk_leading_edges", lead_n, DW);
         end
         lead_n  = 0;
         trail_n = 0;
      end
      if (cs_watch && o_SPI_CS_n != cs_exp) cs_bad++;
   end

   task automatic send_word(input logic [DW-1:0] w, input logic last, input logic [1:0] mode,
                            input logic sel, input logic [DW-1:0] rx_exp);
      int n = 0;
      while (!o_TX_Ready && n < 2000) begin
         @(posedge i_Clk); #1;
         n++;
      end
      check_val("ready_wait", o_TX_Ready, 1);
      if (!o_Busy) begin
         cur_mode = mode;
         lead_n   = 0;
         trail_n  = 0;
      end
      i_TX_Word = w; i_TX_Last = last; i_Mode = mode; i_CS_Sel = sel; i_TX_DV = 1'b1;
      exp_q.push_back(rx_exp);
      rx_total++;
      @(posedge i_Clk); #1;
      i_TX_DV = 1'b0;
   endtask

   task automatic wait_rx(output int cyc);
      cyc = 0;
      do begin
         @(posedge i_Clk); #1;
         cyc++;
      end while (!o_RX_DV && cyc < 2000);
      check_val("rx_timeout", o_RX_DV, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (o_Busy && n < 2000) begin
         @(posedge i_Clk); #1;
         n++;
      end
      check_val("idle_timeout", o_Busy, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, rc;
      #3 i_Rst_L = 1'b0;
      #2;
      check_val("rst_cs_n", o_SPI_CS_n, 2'b11);
      check_val("rst_sclk", o_SPI_Clk, 0);
      check_val("rst_mosi", o_SPI_MOSI, 0);
      check_val("rst_rx_word", o_RX_Word, 0);
      check_val("rst_rx_dv", o_RX_DV, 0);
      check_val("rst_busy", o_Busy, 0);
      check_val("rst_ready", o_TX_Ready, 1);
      repeat (3) @(posedge i_Clk);
      #1 i_Rst_L = 1'b1;
      @(posedge i_Clk); #1;

      // Release outside WAIT_NEXT does nothing
      i_CS_Release = 1'b1;
      @(posedge i_Clk); #1;
      i_CS_Release = 1'b0;
      check_val("release_idle_busy", o_Busy, 0);
      check_val("release_idle_cs", o_SPI_CS_n, 2'b11);

      // Mode 0, single word, loopback, latency
      send_word(8'hA5, 1'b1, 2'd0, 1'b0, 8'hA5);
      check_val("t1_cs_low", o_SPI_CS_n, 2'b10);
      wait_rx(cyc);
      check_val("t1_latency", cyc, LEAD + (2 * DW + 1) * CPHB);
      check_val("t1_cs_released", o_SPI_CS_n, 2'b11);
      wait_idle();

      // Mode 3 three-word burst on CS1
      send_word(8'h12, 1'b0, 2'd3, 1'b1, 8'h12);
      cs_exp = 2'b01; cs_bad = 0; cs_watch = 1'b1;
      send_word(8'h34, 1'b0, 2'd3, 1'b1, 8'h34);
      check_val("t2_sclk_wait_next", o_SPI_Clk, 1);
      send_word(8'h56, 1'b1, 2'd3, 1'b1, 8'h56);
      wait_rx(cyc);
      cs_watch = 1'b0;
      check_val("t2_cs_hold", cs_bad, 0);
      wait_idle();
      check_val("t2_sclk_idle", o_SPI_Clk, 1);
      check_val("t2_cs_idle", o_SPI_CS_n, 2'b11);

      // All modes against a slave returning 0x3C
      use_slave = 1'b1;
      slv_word  = 8'h3C;
      for (int m = 0; m < 4; m++) begin
         logic [1:0] md;
         md = 2'(m);
         send_word(8'h81 + 8'(m), 1'b1, md, 1'b0, 8'h3C);
         wait_idle();
         check_val("t3_sclk_idle", o_SPI_Clk, {31'd0, md[1]});
      end
      use_slave = 1'b0;

      // DV while busy is dropped
      rc = rx_count;
      send_word(8'h11, 1'b1, 2'd0, 1'b0, 8'h11);
      repeat (10) @(posedge i_Clk);
      #1;
      check_val("t4_ready_busy", o_TX_Ready, 0);
      i_TX_Word = 8'h77; i_TX_DV = 1'b1;
      @(posedge i_Clk); #1;
      i_TX_DV = 1'b0;
      wait_idle();
      repeat (3) @(posedge i_Clk);
      #1;
      check_val("t4_rx_count", rx_count, rc + 1);

      // Reset mid-transfer, then a clean word
      send_word(8'h96, 1'b1, 2'd0, 1'b0, 8'h96);
      repeat (16) @(posedge i_Clk);
      #1 i_Rst_L = 1'b0;
      #1;
      check_val("t5_cs_n", o_SPI_CS_n, 2'b11);
      check_val("t5_sclk", o_SPI_Clk, 0);
      check_val("t5_busy", o_Busy, 0);
      exp_q.delete();
      rx_total--;
      rc = rx_count;
      repeat (4) @(posedge i_Clk);
      #1 i_Rst_L = 1'b1;
      repeat (40) @(posedge i_Clk);
      #1;
      check_val("t5_no_rx", rx_count, rc);
      send_word(8'hC3, 1'b1, 2'd0, 1'b0, 8'hC3);
      wait_idle();

      // WAIT_NEXT released without another word
      send_word(8'h5A, 1'b0, 2'd0, 1'b0, 8'h5A);
      wait_rx(cyc);
      check_val("t6_ready_wait_next", o_TX_Ready, 1);
      check_val("t6_cs_held", o_SPI_CS_n, 2'b10);
      i_CS_Release = 1'b1;
      @(posedge i_Clk); #1;
      i_CS_Release = 1'b0;
      check_val("t6_cs_high", o_SPI_CS_n, 2'b11);
      check_val("t6_ready_idle0", o_TX_Ready, 0);
      @(posedge i_Clk); #1;
      check_val("t6_ready_idle1", o_TX_Ready, 0);
      @(posedge i_Clk); #1;
      check_val("t6_ready_back", o_TX_Ready, 1);
      check_val("t6_mosi_idle", o_SPI_MOSI, 0);

      repeat (3) @(posedge i_Clk);
      #1;
      check_val("sb_empty", exp_q.size(), 0);
      check_val("rx_total", rx_count, rx_total);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
